// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT source-side datapath.
package fft_pkg;

    localparam int FFT_NUM      = 16;
    localparam int FFT_DATA     = 512;
    localparam int FFT_IN_WIDTH = 9;

    // One signed component (real or imaginary) of a complex sample.
    typedef logic signed [FFT_IN_WIDTH-1:0] fft_sample_t;

    // Framer state: waiting for a start-of-frame, or collecting a frame.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } framer_state_e;

endpackage

// File: rtl/fft_lane_pack.sv
// Lane packer: writes each accepted sample into its collect lane and, when a vector
// completes, copies the collect array (including the sample written that cycle) to the
// output register. Output and collect are separate so the output stays stable while
// the next vector fills.
module fft_lane_pack
    import fft_pkg::*;
#(
    parameter int IN_WIDTH = FFT_IN_WIDTH,
    parameter int NUM      = FFT_NUM,
    parameter int LW       = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_wr_en,
    input  logic [LW-1:0]                 i_wr_lane,
    input  logic [IN_WIDTH-1:0]           i_re,
    input  logic [IN_WIDTH-1:0]           i_im,
    input  logic                          i_copy,
    output logic [NUM-1:0][IN_WIDTH-1:0]  o_re,
    output logic [NUM-1:0][IN_WIDTH-1:0]  o_im
);

    logic [NUM-1:0][IN_WIDTH-1:0] r_col_re;
    logic [NUM-1:0][IN_WIDTH-1:0] r_col_im;
    logic [NUM-1:0][IN_WIDTH-1:0] r_out_re;
    logic [NUM-1:0][IN_WIDTH-1:0] r_out_im;
    logic [NUM-1:0][IN_WIDTH-1:0] w_next_re;
    logic [NUM-1:0][IN_WIDTH-1:0] w_next_im;

    // Collect array as it will look after this cycle's write; the copy uses it directly
    // so the completing sample lands in the output vector in the same cycle.
    always_comb begin
        w_next_re = r_col_re;
        w_next_im = r_col_im;
        if (i_wr_en) begin
            w_next_re[i_wr_lane] = i_re;
            w_next_im[i_wr_lane] = i_im;
        end
    end

    // Collect and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col_re <= '0;
            r_col_im <= '0;
            r_out_re <= '0;
            r_out_im <= '0;
        end else begin
            if (i_wr_en) begin
                r_col_re <= w_next_re;
                r_col_im <= w_next_im;
            end
            if (i_copy) begin
                r_out_re <= w_next_re;
                r_out_im <= w_next_im;
            end
        end
    end

    assign o_re = r_out_re;
    assign o_im = r_out_im;

endmodule

// File: rtl/fft_lane_framer.sv
// Source-side framer: packs NUM consecutive samples into a lane vector, tracks the
// position within a DATA-sample frame, flags first/last vectors and discards partial
// frames cut short by a new start-of-frame.
// Optional macro FFT_FRAMER_ERR_CNT_EN adds a saturating 16-bit discarded-frame counter
// on port err_cnt.
// Lane elements of dout_re/dout_im are two's-complement values of IN_WIDTH bits.
module fft_lane_framer
    import fft_pkg::*;
#(
    parameter int IN_WIDTH = FFT_IN_WIDTH,
    parameter int NUM      = FFT_NUM,
    parameter int DATA     = FFT_DATA,
    parameter int COUNT    = DATA / NUM
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic signed [IN_WIDTH-1:0]    din_re,
    input  logic signed [IN_WIDTH-1:0]    din_im,
    input  logic                          din_valid,
    input  logic                          din_sof,
    output logic [NUM-1:0][IN_WIDTH-1:0]  dout_re,
    output logic [NUM-1:0][IN_WIDTH-1:0]  dout_im,
    output logic                          valid_out,
    output logic                          dout_sof,
    output logic                          dout_eof,
`ifdef FFT_FRAMER_ERR_CNT_EN
    output logic                          frame_err,
    output logic [15:0]                   err_cnt
`else
    output logic                          frame_err
`endif
);

    localparam int LW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int VW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(NUM - 1);
    localparam logic [VW-1:0] VEC_LAST  = VW'(COUNT - 1);

    framer_state_e r_state;
    logic [LW-1:0] r_lane_cnt;
    logic [VW-1:0] r_vec_cnt;
    logic          r_valid;
    logic          r_sof;
    logic          r_eof;
    logic          r_err;

    logic          w_in_fill;
    logic          w_sof_in;
    logic          w_wr_en;
    logic [LW-1:0] w_wr_lane;
    logic          w_copy;
    logic          w_discard;

    // Decode the accepted sample: where it goes and whether it completes a vector.
    always_comb begin
        w_in_fill = (r_state == FILL);
        w_sof_in  = din_valid && din_sof;
        w_wr_en   = din_valid && (din_sof || w_in_fill);
        w_wr_lane = din_sof ? '0 : r_lane_cnt;
        w_copy    = din_valid && !din_sof && w_in_fill && (r_lane_cnt == LANE_LAST);
        w_discard = w_sof_in && w_in_fill;
    end

    fft_lane_pack #(
        .IN_WIDTH (IN_WIDTH),
        .NUM      (NUM),
        .LW       (LW)
    ) u_pack (
        .clk       (clk),
        .rstn      (rstn),
        .i_wr_en   (w_wr_en),
        .i_wr_lane (w_wr_lane),
        .i_re      (din_re),
        .i_im      (din_im),
        .i_copy    (w_copy),
        .o_re      (dout_re),
        .o_im      (dout_im)
    );

    // Frame state machine, lane/vector counters and registered output flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_lane_cnt <= '0;
            r_vec_cnt  <= '0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_err   <= 1'b0;
            if (din_valid) begin
                if (din_sof) begin
                    // Start of frame always restarts; inside FILL it drops the partial frame.
                    r_err      <= w_in_fill;
                    r_state    <= FILL;
                    r_lane_cnt <= LW'(1);
                    r_vec_cnt  <= '0;
                end else if (w_in_fill) begin
                    if (r_lane_cnt == LANE_LAST) begin
                        r_lane_cnt <= '0;
                        r_valid    <= 1'b1;
                        r_sof      <= (r_vec_cnt == '0);
                        r_eof      <= (r_vec_cnt == VEC_LAST);
                        if (r_vec_cnt == VEC_LAST) begin
                            r_vec_cnt <= '0;
                            r_state   <= IDLE;
                        end else begin
                            r_vec_cnt <= r_vec_cnt + VW'(1);
                        end
                    end else begin
                        r_lane_cnt <= r_lane_cnt + LW'(1);
                    end
                end
            end
        end
    end

    assign valid_out = r_valid;
    assign dout_sof  = r_sof;
    assign dout_eof  = r_eof;
    assign frame_err = r_err;

`ifdef FFT_FRAMER_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of discarded partial frames, in step with frame_err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= '0;
        end else if (w_discard && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_discard;
    assign w_unused_discard = w_discard;
`endif

endmodule

// File: doc/fft_lane_framer.md
# fft_lane_framer

Source-side framer for the FFT datapath. Accepts one complex sample per cycle from the front end, packs NUM consecutive samples into a parallel lane vector, and drives the butterfly stage's lane inputs with a one-cycle valid per vector. Tracks frame position: one frame is DATA samples, which is COUNT vectors. Marks the first and last vector of each frame and discards malformed partial frames.

## Interface
- IN_WIDTH, 9, sample bit width (signed, per component)
- NUM, 16, number of output lanes (power of two)
- DATA, 512, samples per frame (multiple of NUM)
- COUNT, DATA/NUM, vectors per frame
- clk  in  1  clock; all logic is rising-edge
- rstn  in  1  reset, asynchronous assert, active-low
- din_re  in  IN_WIDTH  signed real part of the sample
- din_im  in  IN_WIDTH  signed imaginary part of the sample
- din_valid  in  1  sample is present this cycle
- din_sof  in  1  this sample is sample 0 of a frame; only meaningful with din_valid
- dout_re  out  IN_WIDTH x NUM  signed real lane array; index = lane
- dout_im  out  IN_WIDTH x NUM  signed imaginary lane array
- valid_out  out  1  one-cycle pulse; vector on dout_* is new
- dout_sof  out  1  qualifies valid_out: first vector of the frame
- dout_eof  out  1  qualifies valid_out: vector COUNT-1 of the frame
- frame_err  out  1  one-cycle pulse: a partial frame was discarded
- err_cnt  out  16  discarded-frame count; present only with the macro (see Configuration)

## Operation
- State machine has two states, IDLE and FILL. Counters:
  - lane_cnt: 0..NUM-1, $clog2(NUM) bits
  - vec_cnt: 0..COUNT-1, $clog2(COUNT) bits
- IDLE:
  - din_valid without din_sof: sample dropped silently, no error.
  - din_valid with din_sof: sample written to collect lane 0; lane_cnt=1, vec_cnt=0; go to FILL.
- FILL, din_valid without din_sof:
  - Sample written to collect lane lane_cnt; lane_cnt increments.
  - When lane_cnt==NUM-1, the collect register (with the just-written sample) is copied to the output register. valid_out is raised, dout_sof=(vec_cnt==0), dout_eof=(vec_cnt==COUNT-1). lane_cnt wraps to 0.
  - If vec_cnt==COUNT-1, vec_cnt wraps to 0 and the state returns to IDLE. Otherwise vec_cnt increments.
- FILL, din_valid with din_sof:
  - Current partial frame discarded; frame_err pulses.
  - Vectors already emitted stay emitted.
  - The sample becomes lane 0 of a new frame: lane_cnt=1, vec_cnt=0, state stays FILL.
- din_valid low: no state change. Gaps of any length are allowed mid-vector and mid-frame.
- Collect and output registers are separate, so the output vector stays stable while the next vector fills. With NUM>=2 there is no overrun.
- No arithmetic; samples pass bit-exact. Lane k of a vector holds the k-th accepted sample of that vector.

## Timing
- Reset values:
  - dout_re, dout_im all zero
  - valid_out, dout_sof, dout_eof, frame_err all 0
  - counters 0, state IDLE, err_cnt 0
- All outputs are registered.
- Latency: valid_out is high in the cycle after the NUM-th sample of a vector is accepted, for exactly one cycle.
- dout_* hold their value until the next valid_out.
- frame_err is high in the cycle after the offending din_sof sample.
- Back-to-back frames:
  - The last sample of frame n moves the state to IDLE.
  - A din_sof sample in the very next cycle is accepted with zero gap.
  - The last vector of frame n and lane 0 of frame n+1 overlap in time without loss.
- Reset mid-frame: everything returns to reset values immediately; the next frame needs din_sof.

## Configuration
- FFT_FRAMER_ERR_CNT_EN defined:
  - err_cnt port and register exist.
  - err_cnt increments on each frame_err and saturates at 16'hFFFF.
- Not defined: the port and the logic are absent; frame_err still pulses.

## Structure
- fft_pkg holds:
  - shared constants FFT_NUM=16, FFT_DATA=512, FFT_IN_WIDTH=9
  - typedef of the signed sample type
  - typedef of the framer state enum {IDLE, FILL}
- One sub-module, fft_lane_pack: collect register array plus write enable by lane index, and the copy-to-output on vector complete.
- Counters, state machine and flags live in fft_lane_framer.

## Test plan
- Full frame: sof on sample 0, 512 contiguous samples re=k[8:0], im=-k. Required: 32 valid_out pulses, one every 16 cycles. First vector has lane j = (j,-j) with dout_sof=1. Vector 31 has lane 0 = (496,-496) wrapped to 9 bits, with dout_eof=1. frame_err never pulses.
- Pre-sof junk: 5 valid samples without sof, then a full frame. Required: junk dropped, 32 vectors, first vector lane 0 = first sof sample.
- Mid-frame sof: sof frame, 40 samples, then a new sof. Required: 2 vectors emitted, frame_err pulses 1 cycle after the second sof. The next vector's dout_sof=1 and lane 0 = the second sof sample. With the macro defined, err_cnt=1.
- Gapped input: din_valid toggles 1/0 for a whole frame. Required: identical vectors to the contiguous case; valid_out one cycle after every 16th accepted sample.
- Back-to-back: two frames with zero gap. Required: 64 vectors; dout_eof on vector 31, dout_sof on vector 32; no frame_err.
- Reset at sample 100: rstn low for 2 cycles. Required: all outputs zero; subsequent samples without sof produce no valid_out.
